// File: rtl/io_timer.sv
// Memory-mapped prescaled timer with compare-match interrupt and an 8-word register window.
// Build option: define IO_TIMER_AUTORELOAD_EN for periodic mode; without it the timer is one-shot.
module io_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addresses,
   input  logic        we,
   input  logic        re,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        data_oe,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESCALE = 3'd1;
   localparam logic [2:0] OFF_COMPARE  = 3'd2;
   localparam logic [2:0] OFF_COUNT    = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] compare_q, compare_d;
   logic [15:0] count_q, count_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        match_q, match_d;
   logic        missed_q, missed_d;

   logic [15:0] offset_full;
   logic [2:0]  off;
   logic        in_win;
   logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
   logic        tick, match;
   logic [1:0]  w1c;
   logic [15:0] rdata;

   // Subtracting the base lets addresses below the window wrap to large offsets.
   assign offset_full = addresses - BASE_ADDR;
   assign in_win      = (offset_full[15:3] == 13'd0);
   assign off         = offset_full[2:0];

   assign wr_ctrl     = we && in_win && (off == OFF_CTRL);
   assign wr_prescale = we && in_win && (off == OFF_PRESCALE);
   assign wr_compare  = we && in_win && (off == OFF_COMPARE);
   assign wr_count    = we && in_win && (off == OFF_COUNT);
   assign wr_status   = we && in_win && (off == OFF_STATUS);

   // A COUNT write at a tick edge swallows that tick, including any match it would cause.
   assign tick  = en_q && (pcnt_q == prescale_q);
   assign match = tick && !wr_count && (count_q == compare_q);
   assign w1c   = wr_status ? data_in[1:0] : 2'b00;

   always_comb begin
      // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
      en_d       = en_q;
      ie_d       = ie_q;
      prescale_d = prescale_q;
      compare_d  = compare_q;
      count_d    = count_q;
      pcnt_d     = pcnt_q;

      if (en_q) begin
         pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      end
      if (tick) begin
         count_d = match ? 16'd0 : count_q + 16'd1;
      end

      if (wr_ctrl) begin
         en_d = data_in[0];
         ie_d = data_in[1];
         if (data_in[0] && !en_q) begin
            pcnt_d = 16'd0;
         end
      end
      if (wr_prescale) prescale_d = data_in;
      if (wr_compare)  compare_d  = data_in;
      if (wr_count) begin
         count_d = data_in;
         pcnt_d  = 16'd0;
      end

`ifndef IO_TIMER_AUTORELOAD_EN
      if (match) en_d = 1'b0;
`endif

      // Set beats a coincident write-1-to-clear.
      match_d  = match | (match_q & ~w1c[0]);
      missed_d = (match & match_q) | (missed_q & ~w1c[1]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         prescale_q <= 16'h0000;
         compare_q  <= 16'hFFFF;
         count_q    <= 16'h0000;
         pcnt_q     <= 16'h0000;
         match_q    <= 1'b0;
         missed_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge state.
         en_q       <= en_d;
         ie_q       <= ie_d;
         prescale_q <= prescale_d;
         compare_q  <= compare_d;
         count_q    <= count_d;
         pcnt_q     <= pcnt_d;
         match_q    <= match_d;
         missed_q   <= missed_d;
      end
   end

   assign irq = match_q & ie_q;

   always_comb begin
      rdata = 16'h0000;
      case (off)
         OFF_CTRL:     rdata = {14'd0, ie_q, en_q};
         OFF_PRESCALE: rdata = prescale_q;
         OFF_COMPARE:  rdata = compare_q;
         OFF_COUNT:    rdata = count_q;
         OFF_STATUS:   rdata = {14'd0, missed_q, match_q};
         default:      rdata = 16'h0000;
      endcase
   end

   assign data_oe  = re & in_win;
   assign data_out = data_oe ? rdata : 16'h0000;

endmodule

// File: tb/tb_io_timer.sv
// Directed, table-driven bench for io_timer; expectations follow the build mode macro.
module tb_io_timer;

   localparam logic [15:0] BASE = 16'hFF00;

   logic        clk;
   logic        reset;
   logic [15:0] addresses;
   logic        we;
   logic        re;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        data_oe;
   logic        irq;

   int checks = 0;
   int errors = 0;

   io_timer #(.BASE_ADDR(BASE)) dut (
      .clk      (clk),
      .reset    (reset),
      .addresses(addresses),
      .we       (we),
      .re       (re),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_read;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic        rd_en;
      logic [15:0] exp_data;
      logic        exp_oe;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit is_read, logic [15:0] addr, logic [15:0] wdata,
                               logic rd_en, logic [15:0] exp_data, logic exp_oe);
      vec_t v;
      v.is_read = is_read; v.addr = addr; v.wdata = wdata;
      v.rd_en = rd_en; v.exp_data = exp_data; v.exp_oe = exp_oe;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [15:0] wdata);
      @(negedge clk);
      addresses = addr; data_in = wdata; we = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0; addresses = 16'h0000; data_in = 16'h0000;
   endtask

   task automatic bus_read(input logic [15:0] addr, input logic rd_en,
                           output logic [15:0] d, output logic oe);
      addresses = addr; re = rd_en;
      #1;
      d = data_out; oe = data_oe;
      re = 1'b0; addresses = 16'h0000;
   endtask

   task automatic check_reg(input string name, input logic [2:0] offs, input logic [15:0] exp);
      logic [15:0] d;
      logic        oe;
      bus_read(BASE + {13'd0, offs}, 1'b1, d, oe);
      check(name, d, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [15:0] rd;
   logic        oe;

   initial begin
      reset = 1'b0; addresses = 16'h0000; we = 1'b0; re = 1'b0; data_in = 16'h0000;
      #23 reset = 1'b1;
      #3;

      // Reset state
      check("reset_irq", irq, 1'b0);
      check("reset_oe_idle", data_oe, 1'b0);
      check("reset_dout_idle", data_out, 16'h0000);
      check_reg("reset_ctrl", 3'd0, 16'h0000);
      check_reg("reset_prescale", 3'd1, 16'h0000);
      check_reg("reset_compare", 3'd2, 16'hFFFF);
      check_reg("reset_count", 3'd3, 16'h0000);
      check_reg("reset_status", 3'd4, 16'h0000);

      // Register access and bus decode table (timer disabled throughout)
      vecs.push_back(mk(0, BASE + 16'd1, 16'h1234, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd1, 16'h0000, 1, 16'h1234, 1));
      vecs.push_back(mk(0, BASE + 16'd2, 16'hABCD, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd2, 16'h0000, 1, 16'hABCD, 1));
      vecs.push_back(mk(0, BASE + 16'd0, 16'hFFFC, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd0, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(0, BASE + 16'd0, 16'hFFFE, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd0, 16'h0000, 1, 16'h0002, 1));
      vecs.push_back(mk(0, BASE + 16'd0, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd6, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(0, BASE + 16'd5, 16'hFFFF, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd5, 16'h0000, 1, 16'h0000, 1));
      vecs.push_back(mk(1, 16'h0000,     16'h0000, 1, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd1, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk(0, BASE + 16'd8, 16'h5555, 0, 16'h0000, 0));
      vecs.push_back(mk(0, 16'h0001,     16'h7777, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd1, 16'h0000, 1, 16'h1234, 1));
      vecs.push_back(mk(1, BASE + 16'd2, 16'h0000, 1, 16'hABCD, 1));
      vecs.push_back(mk(0, BASE + 16'd3, 16'h0042, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd3, 16'h0000, 1, 16'h0042, 1));
      vecs.push_back(mk(0, BASE + 16'd3, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk(1, BASE + 16'd4, 16'h0000, 1, 16'h0000, 1));

      foreach (vecs[i]) begin
         if (vecs[i].is_read) begin
            bus_read(vecs[i].addr, vecs[i].rd_en, rd, oe);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_oe", i), oe, vecs[i].exp_oe);
         end else begin
            bus_write(vecs[i].addr, vecs[i].wdata);
         end
      end

      // Periodic / one-shot: PRESCALE=3, COMPARE=4 -> match 20 edges after EN write
      bus_write(BASE + 16'd1, 16'd3);
      bus_write(BASE + 16'd2, 16'd4);
      bus_write(BASE + 16'd0, 16'h0003);
      for (int k = 1; k <= 19; k++) begin
         tick(1);
         if (k == 4)  check_reg("per_count_e4", 3'd3, 16'd1);
         if (k == 16) check_reg("per_count_e16", 3'd3, 16'd4);
         if (k == 19) check("per_irq_e19", irq, 1'b0);
      end
      tick(1);
      check("per_irq_e20", irq, 1'b1);
      check_reg("per_status_e20", 3'd4, 16'h0001);
      check_reg("per_count_e20", 3'd3, 16'h0000);
`ifdef IO_TIMER_AUTORELOAD_EN
      check_reg("per_ctrl_e20", 3'd0, 16'h0003);
      tick(20);
      check_reg("per_status_e40", 3'd4, 16'h0003);
      check("per_irq_e40", irq, 1'b1);
      check_reg("per_count_e40", 3'd3, 16'h0000);
`else
      check_reg("oneshot_ctrl_e20", 3'd0, 16'h0002);
      tick(20);
      check_reg("oneshot_status_e40", 3'd4, 16'h0001);
      check_reg("oneshot_count_e40", 3'd3, 16'h0000);
      check_reg("oneshot_ctrl_e40", 3'd0, 16'h0002);
`endif

      // Plain write-1-to-clear
      bus_write(BASE + 16'd0, 16'h0002);
      bus_write(BASE + 16'd4, 16'h0003);
      check_reg("w1c_status", 3'd4, 16'h0000);
      check("w1c_irq", irq, 1'b0);

      // COUNT write on a tick edge wins over the increment
      bus_write(BASE + 16'd0, 16'h0000);
      bus_write(BASE + 16'd2, 16'h0100);
      bus_write(BASE + 16'd3, 16'h0000);
      bus_write(BASE + 16'd0, 16'h0001);
      tick(7);
      bus_write(BASE + 16'd3, 16'h0010);
      check_reg("cnt_race_load", 3'd3, 16'h0010);
      tick(3);
      check_reg("cnt_race_hold3", 3'd3, 16'h0010);
      tick(1);
      check_reg("cnt_race_tick4", 3'd3, 16'h0011);

      // First match, then W1C of MATCH on the edge of a second match
      bus_write(BASE + 16'd0, 16'h0000);
      bus_write(BASE + 16'd2, 16'd4);
      bus_write(BASE + 16'd4, 16'h0003);
      bus_write(BASE + 16'd3, 16'h0000);
      bus_write(BASE + 16'd0, 16'h0003);
      tick(20);
      check_reg("race_first_status", 3'd4, 16'h0001);
      bus_write(BASE + 16'd0, 16'h0002);
      bus_write(BASE + 16'd3, 16'h0000);
      bus_write(BASE + 16'd0, 16'h0003);
      tick(19);
      bus_write(BASE + 16'd4, 16'h0001);
      check_reg("race_w1c_status", 3'd4, 16'h0003);
      check("race_w1c_irq", irq, 1'b1);

      // Asynchronous reset mid-cycle with irq high
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("areset_irq", irq, 1'b0);
      check_reg("areset_count", 3'd3, 16'h0000);
      check_reg("areset_compare", 3'd2, 16'hFFFF);
      check_reg("areset_ctrl", 3'd0, 16'h0000);
      @(negedge clk);
      reset = 1'b1;
      tick(25);
      check_reg("post_reset_count", 3'd3, 16'h0000);
      check_reg("post_reset_status", 3'd4, 16'h0000);
      check("post_reset_irq", irq, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_timer.md
IO_TIMER -- requirements
Module: io_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00: first address of the 8-word register window (BASE_ADDR..BASE_ADDR+7).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 addresses  input  16  CPU bus address.
REQ-005 we  input  1  write strobe, sampled at rising edge when address in window.
REQ-006 re  input  1  read strobe.
REQ-007 data_in  input  16  write data from CPU bus.
REQ-008 data_out  output  16  read data; valid combinationally while re and address in window.
REQ-009 data_oe  output  1  high when re and address in window; top level uses it to drive shared data bus.
REQ-010 irq  output  1  level interrupt request to one interrupt-manager input bit.

Function
REQ-011 Register map (offset from BASE_ADDR): 0 CTRL, 1 PRESCALE, 2 COMPARE, 3 COUNT, 4 STATUS; offsets 5-7 read 16'h0000, writes ignored.
REQ-012 CTRL: bit0 EN, bit1 IE; bits 15:2 read 0, writes ignored.
REQ-013 Prescaler counter pcnt (16 bit, internal): while EN=1, increments each cycle; when pcnt==PRESCALE a tick occurs and pcnt returns to 0; tick period = PRESCALE+1 cycles.
REQ-014 While EN=0: pcnt and COUNT hold; no ticks.
REQ-015 Write of CTRL with EN changing 0->1 clears pcnt; first tick occurs PRESCALE+1 cycles after that write edge.
REQ-016 On tick with COUNT!=COMPARE: COUNT increments by 1, 16-bit wrap 16'hFFFF->0 without event.
REQ-017 On tick with COUNT==COMPARE (match): COUNT<=0 and STATUS.MATCH<=1 at the same edge; irq high from the following cycle if IE=1.
REQ-018 Match while STATUS.MATCH already 1 sets STATUS.MISSED (bit1).
REQ-019 STATUS is write-1-to-clear per bit; set and clear of the same bit at the same edge: set wins.
REQ-020 irq = STATUS.MATCH & CTRL.IE, derived from registered state only (glitch-free).
REQ-021 Write to COUNT loads data_in and clears pcnt; coincident tick at that edge is discarded (write wins).
REQ-022 Write to PRESCALE or COMPARE takes effect for comparisons from the next cycle; pcnt>PRESCALE after a write counts up and wraps through 16'hFFFF to 0 before first tick.
REQ-023 Reads have no side effects; data_out = 0 when data_oe=0.
REQ-024 Address outside window: no register change, data_oe=0.

Reset
REQ-025 reset low asynchronously forces CTRL=0, PRESCALE=0, COMPARE=16'hFFFF, COUNT=0, STATUS=0, pcnt=0; hence irq=0, data_oe=0, data_out=0.
REQ-026 Reset asserted mid-count discards count progress and pending interrupt; release is followed by no tick until EN is written 1.

Configuration
REQ-027 Macro IO_TIMER_AUTORELOAD_EN defined: after match timer keeps running (EN stays 1), periodic events every (COMPARE+1)*(PRESCALE+1) cycles.
REQ-028 Macro IO_TIMER_AUTORELOAD_EN undefined: one-shot; match clears CTRL.EN at the same edge COUNT<=0; IE unaffected.

Verification
REQ-029 Reset: drive reset=0 mid-run with irq=1 -> irq=0, COUNT=0, COMPARE reads 16'hFFFF immediately, no clk edge needed.
REQ-030 Periodic: PRESCALE=3, COMPARE=4, CTRL=3 (autoreload) -> first MATCH/irq 20 cycles after EN write edge, then every 20 cycles; COUNT reads 0..4.
REQ-031 One-shot (macro undefined): same setup -> single irq at cycle 20, CTRL reads 16'h0002 afterwards, COUNT stays 0.
REQ-032 W1C race: write STATUS=16'h0001 on the exact edge of a second match -> MATCH stays 1, MISSED=1, irq remains high.
REQ-033 COUNT write race: write COUNT=16'h0010 on a tick edge -> COUNT reads 16'h0010, not 16'h0011; next tick 4 cycles later (PRESCALE=3).
REQ-034 Bus decode: read BASE_ADDR+6 -> data_oe=1, data_out=0; read 16'h0000 -> data_oe=0; write BASE_ADDR+8 -> no register changes.
